// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with an added parity_err pulse output.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             rx,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] count,
  output logic             frame_err,
  output logic             overflow,
  input  logic             ovf_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd5;
  localparam logic [2:0] S_POST_DATA = S_PARITY;
`else
  localparam logic [2:0] S_POST_DATA = S_STOP;
`endif

  logic              rx_meta_q, rxs_q;
  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              ferr_q, ferr_d;
  logic              push;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              pop, full, wr_en, drop;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      // Every entry into IDLE happens with rxs high, so a low rxs here is a 1-to-0 edge.
      S_IDLE: begin
        if (!rxs_q) begin
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_POST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          par_d   = rxs_q;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          ferr_d  = ~rxs_q;
`ifdef UART_RX_PARITY_EN
          perr_d  = ^{shift_q, par_q};
          push    = rxs_q & ~perr_d;
`else
          push    = rxs_q;
`endif
          state_d = rxs_q ? S_IDLE : S_WAIT_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // When full, a simultaneous pop frees the head slot that wr_ptr also addresses.
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & rd_ready;
  assign full     = (count_q == CNT_FULL);
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && pop) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (default 8N1 build): frame table plus
// directed sequences for glitches, framing errors, overflow and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLKS  = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  // Edge count from the start-bit drive to the stop-bit sample edge.
  localparam int STOP_EDGE = 3 + CLKS / 2 + 9 * CLKS;

  logic          clock = 1'b0;
  logic          resetb = 1'b0;
  logic          rx = 1'b1;
  logic          rd_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  logic [7:0] sb[$];
  logic [7:0] sb_exp;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    bit         exp_push;
    int         exp_ferr;
  } vec_t;
  vec_t vecs[7];

  uart_rx_fifo #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock(clock), .resetb(resetb), .rx(rx),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .frame_err(frame_err), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every accepted read must match the oldest expected byte.
  always @(negedge clock) begin
    #1;
    if (resetb) begin
      if (frame_err) ferr_cnt++;
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no data (cycle %0d)", rd_data, cyc);
        end else begin
          sb_exp = sb.pop_front();
          chk("rd_data", 32'(rd_data), 32'(sb_exp));
        end
      end
    end
  end

  // Called on a negedge. strobe: 0 none, 1 rd_ready, 2 ovf_clr during the stop-sample cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit lat, input int strobe);
    int st;
    st = cyc;
    rx = 1'b0;
    repeat (CLKS) @(negedge clock);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      repeat (CLKS) @(negedge clock);
    end
    rx = stop;
    for (int j = 0; j < CLKS; j++) begin
      if (cyc == st + STOP_EDGE - 1) begin
        if (strobe == 1) rd_ready = 1'b1;
        if (strobe == 2) ovf_clr = 1'b1;
        if (lat) chk("valid_before_push", 32'(rd_valid), 32'd0);
      end
      if (cyc == st + STOP_EDGE) begin
        if (strobe == 1) rd_ready = 1'b0;
        if (strobe == 2) ovf_clr = 1'b0;
        if (lat) chk("valid_after_push", 32'(rd_valid), 32'd1);
      end
      if (lat && cyc == st + STOP_EDGE + 1) chk("valid_one_cycle", 32'(rd_valid), 32'd0);
      @(negedge clock);
    end
    rx = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 0,  1'b1, 0};
    vecs[1] = '{8'hA3, 1'b1, 0,  1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 0,  1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 0,  1'b1, 0};
    vecs[4] = '{8'h41, 1'b0, 40, 1'b0, 1};
    vecs[5] = '{8'h42, 1'b1, 0,  1'b1, 0};
    vecs[6] = '{8'h81, 1'b1, 0,  1'b1, 0};

    repeat (2) @(negedge clock);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    resetb = 1'b1;
    repeat (5) @(negedge clock);

    rd_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ferr_cnt = 0;
      if (vecs[i].exp_push) sb.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].exp_push, 0);
      if (vecs[i].hold_low > 0) begin
        rx = 1'b0;
        repeat (vecs[i].hold_low) @(negedge clock);
        rx = 1'b1;
      end
      repeat (20) @(negedge clock);
      chk("vec_frame_err", 32'(ferr_cnt), 32'(vecs[i].exp_ferr));
      chk("vec_count", 32'(count), 32'h0);
      chk("vec_sb_drained", 32'(sb.size()), 32'h0);
    end

    // Short low glitch must be rejected as a false start.
    ferr_cnt = 0;
    rx = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    repeat (30) @(negedge clock);
    chk("glitch_count", 32'(count), 32'h0);
    chk("glitch_valid", 32'(rd_valid), 32'h0);
    chk("glitch_frame_err", 32'(ferr_cnt), 32'h0);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1, 0);
    repeat (4) @(negedge clock);
    chk("glitch_recover_sb", 32'(sb.size()), 32'h0);

    // Overflow: nine bytes into an eight-deep FIFO with no reads.
    rd_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= DEPTH) sb.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0, 0);
    end
    repeat (4) @(negedge clock);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_head_hold", 32'(rd_data), 32'h01);
    send_frame(8'h0A, 1'b1, 1'b0, 2);
    repeat (2) @(negedge clock);
    chk("ovf_set_beats_clr", 32'(overflow), 32'h1);
    chk("ovf_count_again", 32'(count), 32'(DEPTH));
    rd_ready = 1'b1;
    repeat (12) @(negedge clock);
    rd_ready = 1'b0;
    chk("ovf_drain_count", 32'(count), 32'h0);
    chk("ovf_drain_sb", 32'(sb.size()), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'h0);

    // Full FIFO with a pop on the exact push cycle: push accepted, no overflow.
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(8'h11 + 8'(i));
      send_frame(8'h11 + 8'(i), 1'b1, 1'b0, 0);
    end
    repeat (2) @(negedge clock);
    chk("full_count", 32'(count), 32'(DEPTH));
    sb.push_back(8'h19);
    send_frame(8'h19, 1'b1, 1'b0, 1);
    repeat (2) @(negedge clock);
    chk("full_pop_count", 32'(count), 32'(DEPTH));
    chk("full_pop_no_ovf", 32'(overflow), 32'h0);
    rd_ready = 1'b1;
    repeat (12) @(negedge clock);
    chk("full_pop_drain_sb", 32'(sb.size()), 32'h0);
    chk("full_pop_drain_count", 32'(count), 32'h0);

    // Reset mid-frame: preloaded byte and partial 0x7E are both lost.
    rd_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    repeat (4) @(negedge clock);
    chk("pre_rst_count", 32'(count), 32'h1);
    chk("pre_rst_data", 32'(rd_data), 32'h5A);
    rx = 1'b0;
    repeat (CLKS) @(negedge clock);
    for (int b = 0; b < 4; b++) begin
      rx = b[0] ? 1'b1 : (b == 0 ? 1'b0 : 1'b1);
      repeat (CLKS) @(negedge clock);
    end
    rx = 1'b1;
    repeat (CLKS / 2) @(negedge clock);
    resetb = 1'b0;
    #1;
    chk("mid_rst_rd_data", 32'(rd_data), 32'h0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    repeat (20) @(negedge clock);
    chk("post_rst_count", 32'(count), 32'h0);
    rd_ready = 1'b1;
    sb.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b1, 0);
    repeat (10) @(negedge clock);
    chk("post_rst_sb", 32'(sb.size()), 32'h0);
    chk("post_rst_final_count", 32'(count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
